// File: rtl/dm_port_ctrl.sv
// rtl/dm_port_ctrl.sv - splits word read/write requests into four byte beats on the pixel memory port
// Optional macro DMC_ADDR_RANGE_CHECK_EN rejects requests whose word address is >= DM_WORDS.
module dm_port_ctrl #(
  parameter int MEM_RD_LAT = 1,
  parameter int DM_WORDS   = 1048576
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [19:0] dm_addr,
  input  logic        dm_r,
  input  logic        dm_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_data,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t      state_q;
  logic [1:0]  beat_q;
  logic [2:0]  cnt_q;
  logic [19:0] addr_q;
  logic [31:0] wdata_q;
  logic [23:0] shadow_q;
  logic        busy_q;
  logic        done_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic [31:0] rd_data_q;
  logic [21:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic [1:0]  beat_nx;

  assign beat_nx = beat_q + 2'd1;

`ifdef DMC_ADDR_RANGE_CHECK_EN
  logic err_q;
  logic oor;
  assign oor = ({12'd0, dm_addr} >= 32'(DM_WORDS));
  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (DM_WORDS == 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      cnt_q       <= 3'd0;
      addr_q      <= 20'd0;
      wdata_q     <= 32'd0;
      shadow_q    <= 24'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_data_q   <= 32'd0;
      mem_addr_q  <= 22'd0;
      mem_wdata_q <= 8'd0;
`ifdef DMC_ADDR_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // Strobes and pulses are one cycle wide unless a state re-arms them.
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
`ifdef DMC_ADDR_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (dm_wr || dm_r) begin
            addr_q <= dm_addr;
            beat_q <= 2'd0;
`ifdef DMC_ADDR_RANGE_CHECK_EN
            if (oor) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else
`endif
            if (dm_wr) begin
              state_q     <= WR_BEAT;
              wdata_q     <= wr_data;
              busy_q      <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {dm_addr, 2'd0};
              mem_wdata_q <= wr_data[7:0];
            end else begin
              state_q    <= RD_ISSUE;
              busy_q     <= 1'b1;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {dm_addr, 2'd0};
            end
          end
        end
        WR_BEAT: begin
          if (beat_q == 2'd3) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            beat_q      <= beat_nx;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {addr_q, beat_nx};
            mem_wdata_q <= wdata_q[{beat_nx, 3'b000} +: 8];
          end
        end
        RD_ISSUE: begin
          state_q <= RD_WAIT;
          cnt_q   <= 3'(MEM_RD_LAT);
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            // The last byte goes straight into rd_data so it is visible during DONE.
            if (beat_q == 2'd3) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              rd_data_q <= {mem_rdata, shadow_q};
            end else begin
              shadow_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
              beat_q     <= beat_nx;
              state_q    <= RD_ISSUE;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {addr_q, beat_nx};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule
